// File: rtl/pong_if.sv
// Host-side bundle for pong_engine: frame strobe and buttons in, registered display state out.
interface pong_if;
    // frame_tick is a one-cycle valid with no ready: the engine accepts every tick and
    // presents the new frame on its registered outputs right after the sampling edge.
    logic       frame_tick;
    logic       launch;
    logic       p1_up;
    logic       p1_down;
    logic       p2_up;
    logic       p2_down;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] p1_y;
    logic [9:0] p2_y;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] state;
    logic       winner;
    logic       point_pulse;

    modport master (
        output frame_tick, launch, p1_up, p1_down, p2_up, p2_down,
        input  ball_x, ball_y, p1_y, p2_y, score_p1, score_p2, state, winner, point_pulse
    );

    modport slave (
        input  frame_tick, launch, p1_up, p1_down, p2_up, p2_down,
        output ball_x, ball_y, p1_y, p2_y, score_p1, score_p2, state, winner, point_pulse
    );
endinterface

// File: rtl/pong_engine.sv
// Frame-rate pong engine: serve/play/point/game-over FSM, ball and paddle kinematics,
// exact-coordinate collision, rally speed-up and scoring. All outputs are registered.
module pong_engine #(
    parameter int H_SCREEN      = 640,
    parameter int V_SCREEN      = 480,
    parameter int BORDER        = 10,
    parameter int BALL_SIZE     = 10,
    parameter int P_WIDTH       = 8,
    parameter int P_HIGH        = 96,
    parameter int P_OFFSET      = 20,
    parameter int P_SPEED       = 2,
    parameter int SPEED_INIT    = 2,
    parameter int SPEED_MAX     = 6,
    parameter int HITS_PER_STEP = 4,
    parameter int WIN_SCORE     = 9,
    parameter int POINT_FRAMES  = 60
) (
    input  logic  clk,
    input  logic  reset,
    pong_if.slave bus
);
    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [9:0] P1_FACE   = 10'(BORDER + P_OFFSET + P_WIDTH);
    localparam logic [9:0] P2_FACE   = 10'(H_SCREEN - BORDER - P_OFFSET - P_WIDTH - BALL_SIZE);
    localparam logic [9:0] X_WALL    = 10'(H_SCREEN - BORDER - BALL_SIZE);
    localparam logic [9:0] Y_MAX     = 10'(V_SCREEN - BORDER - BALL_SIZE);
    localparam logic [9:0] PY_MAX    = 10'(V_SCREEN - BORDER - P_HIGH);
    localparam logic [9:0] PY_MID    = 10'((V_SCREEN - P_HIGH) / 2);
    localparam logic [9:0] SERVE_OFS = 10'((P_HIGH - BALL_SIZE) / 2);
    localparam logic [9:0] WALL      = 10'(BORDER);
    localparam logic [9:0] BALL      = 10'(BALL_SIZE);
    localparam logic [9:0] PAD_H     = 10'(P_HIGH);
    localparam logic [9:0] PAD_STEP  = 10'(P_SPEED);
    localparam logic [3:0] SPD_INIT  = 4'(SPEED_INIT);
    localparam logic [3:0] SPD_MAX   = 4'(SPEED_MAX);
    localparam logic [3:0] HIT_STEP  = 4'(HITS_PER_STEP);
    localparam logic [3:0] WIN       = 4'(WIN_SCORE);
    localparam logic [7:0] PT_LAST   = 8'(POINT_FRAMES - 1);

    state_e     state_q, state_d;
    logic       server_q, server_d;      // 0 = p1 serves, 1 = p2 serves
    logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [9:0] p1_y_q, p1_y_d, p2_y_q, p2_y_d;
    logic       dx_q, dx_d, dy_q, dy_d;  // dx 1 = right, dy 1 = down
    logic [3:0] speed_q, speed_d, hit_q, hit_d;
    logic [3:0] score_p1_q, score_p1_d, score_p2_q, score_p2_d;
    logic       winner_q, winner_d, point_pulse_q, point_pulse_d;
    logic [7:0] pt_cnt_q, pt_cnt_d;

    logic [9:0] p1_n, p2_n, sp, serve_py;
    logic       ov1, ov2, hit_event, miss, p2_scores, load_serve, serve_side;

    function automatic logic [9:0] paddle_step(input logic [9:0] py, input logic up, input logic dn);
        if (up) return (py < WALL + PAD_STEP) ? WALL : py - PAD_STEP;
        if (dn) return (py + PAD_STEP > PY_MAX) ? PY_MAX : py + PAD_STEP;
        return py;
    endfunction

    always_comb begin
        state_d       = state_q;
        server_d      = server_q;
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        p1_y_d        = p1_y_q;
        p2_y_d        = p2_y_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        speed_d       = speed_q;
        hit_d         = hit_q;
        score_p1_d    = score_p1_q;
        score_p2_d    = score_p2_q;
        winner_d      = winner_q;
        point_pulse_d = 1'b0;
        pt_cnt_d      = pt_cnt_q;
        hit_event     = 1'b0;
        miss          = 1'b0;
        p2_scores     = 1'b0;
        load_serve    = 1'b0;
        serve_side    = server_q;
        serve_py      = p1_y_q;
        sp            = {6'd0, speed_q};
        p1_n          = paddle_step(p1_y_q, bus.p1_up, bus.p1_down);
        p2_n          = paddle_step(p2_y_q, bus.p2_up, bus.p2_down);
        ov1           = (ball_y_q + BALL > p1_y_q) && (ball_y_q < p1_y_q + PAD_H);
        ov2           = (ball_y_q + BALL > p2_y_q) && (ball_y_q < p2_y_q + PAD_H);

        if (bus.frame_tick) begin
            unique case (state_q)
                ST_SERVE: begin
                    p1_y_d     = p1_n;
                    p2_y_d     = p2_n;
                    load_serve = 1'b1;
                    serve_py   = server_q ? p2_n : p1_n;
                    if (bus.launch) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    p1_y_d = p1_n;
                    p2_y_d = p2_n;
                    // Collision tests use this frame's pre-update paddle positions.
                    if (!dx_q) begin
                        if (ball_x_q <= P1_FACE + sp && ball_x_q >= P1_FACE && ov1) begin
                            ball_x_d  = P1_FACE;
                            dx_d      = 1'b1;
                            hit_event = 1'b1;
                        end else if (ball_x_q < WALL + sp) begin
                            miss      = 1'b1;
                            p2_scores = 1'b1;
                        end else begin
                            ball_x_d = ball_x_q - sp;
                        end
                    end else begin
                        if (ball_x_q + sp >= P2_FACE && ball_x_q <= P2_FACE && ov2) begin
                            ball_x_d  = P2_FACE;
                            dx_d      = 1'b0;
                            hit_event = 1'b1;
                        end else if (ball_x_q + sp > X_WALL) begin
                            miss = 1'b1;
                        end else begin
                            ball_x_d = ball_x_q + sp;
                        end
                    end
                    if (!dy_q) begin
                        if (ball_y_q < WALL + sp) begin
                            ball_y_d = WALL;
                            dy_d     = 1'b1;
                        end else begin
                            ball_y_d = ball_y_q - sp;
                        end
                    end else begin
                        if (ball_y_q + sp > Y_MAX) begin
                            ball_y_d = Y_MAX;
                            dy_d     = 1'b0;
                        end else begin
                            ball_y_d = ball_y_q + sp;
                        end
                    end
                end
                ST_POINT: begin
                    if (pt_cnt_q == PT_LAST) begin
                        if (score_p1_q == WIN) begin
                            state_d  = ST_OVER;
                            winner_d = 1'b0;
                        end else if (score_p2_q == WIN) begin
                            state_d  = ST_OVER;
                            winner_d = 1'b1;
                        end else begin
                            state_d    = ST_SERVE;
                            load_serve = 1'b1;
                            serve_py   = server_q ? p2_y_q : p1_y_q;
                        end
                    end else begin
                        pt_cnt_d = pt_cnt_q + 8'd1;
                    end
                end
                ST_OVER: begin
                    if (bus.launch) begin
                        state_d    = ST_SERVE;
                        score_p1_d = '0;
                        score_p2_d = '0;
                        p1_y_d     = PY_MID;
                        p2_y_d     = PY_MID;
                        server_d   = ~winner_q;
                        load_serve = 1'b1;
                        serve_side = ~winner_q;
                        serve_py   = PY_MID;
                    end
                end
            endcase
        end

        if (hit_event) begin
            if (hit_q + 4'd1 >= HIT_STEP) begin
                hit_d   = '0;
                speed_d = (speed_q < SPD_MAX) ? speed_q + 4'd1 : SPD_MAX;
            end else begin
                hit_d = hit_q + 4'd1;
            end
        end

        // On a miss the ball holds its column; the vertical step above still applies.
        if (miss) begin
            state_d       = ST_POINT;
            pt_cnt_d      = '0;
            point_pulse_d = 1'b1;
            if (p2_scores) begin
                score_p2_d = score_p2_q + 4'd1;
                server_d   = 1'b0;
            end else begin
                score_p1_d = score_p1_q + 4'd1;
                server_d   = 1'b1;
            end
        end

        if (load_serve) begin
            ball_x_d = serve_side ? P2_FACE : P1_FACE;
            ball_y_d = serve_py + SERVE_OFS;
            dx_d     = ~serve_side;
            dy_d     = 1'b1;
            speed_d  = SPD_INIT;
            hit_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_SERVE;
            server_q      <= 1'b0;
            ball_x_q      <= P1_FACE;
            ball_y_q      <= PY_MID + SERVE_OFS;
            p1_y_q        <= PY_MID;
            p2_y_q        <= PY_MID;
            dx_q          <= 1'b1;
            dy_q          <= 1'b1;
            speed_q       <= SPD_INIT;
            hit_q         <= '0;
            score_p1_q    <= '0;
            score_p2_q    <= '0;
            winner_q      <= 1'b0;
            point_pulse_q <= 1'b0;
            pt_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            server_q      <= server_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            p1_y_q        <= p1_y_d;
            p2_y_q        <= p2_y_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            speed_q       <= speed_d;
            hit_q         <= hit_d;
            score_p1_q    <= score_p1_d;
            score_p2_q    <= score_p2_d;
            winner_q      <= winner_d;
            point_pulse_q <= point_pulse_d;
            pt_cnt_q      <= pt_cnt_d;
        end
    end

    assign bus.ball_x      = ball_x_q;
    assign bus.ball_y      = ball_y_q;
    assign bus.p1_y        = p1_y_q;
    assign bus.p2_y        = p2_y_q;
    assign bus.score_p1    = score_p1_q;
    assign bus.score_p2    = score_p2_q;
    assign bus.state       = state_q;
    assign bus.winner      = winner_q;
    assign bus.point_pulse = point_pulse_q;
endmodule

// File: tb/tb_pong_engine.sv
// Randomised scoreboard bench for pong_engine against a frame-level game model.
module tb_pong_engine;
    localparam int H_SCREEN = 640, V_SCREEN = 480, BORDER = 10, BALL_SIZE = 10;
    localparam int P_WIDTH = 8, P_HIGH = 96, P_OFFSET = 20, P_SPEED = 2;
    localparam int SPEED_INIT = 2, SPEED_MAX = 6, HITS_PER_STEP = 4;
    localparam int WIN_SCORE = 9, POINT_FRAMES = 60;
    localparam int P1_FACE   = BORDER + P_OFFSET + P_WIDTH;
    localparam int P2_FACE   = H_SCREEN - BORDER - P_OFFSET - P_WIDTH - BALL_SIZE;
    localparam int X_WALL    = H_SCREEN - BORDER - BALL_SIZE;
    localparam int Y_MAX     = V_SCREEN - BORDER - BALL_SIZE;
    localparam int PY_MAX    = V_SCREEN - BORDER - P_HIGH;
    localparam int PY_MID    = (V_SCREEN - P_HIGH) / 2;
    localparam int SERVE_OFS = (P_HIGH - BALL_SIZE) / 2;
    localparam int W = 52;

    logic clk = 1'b0;
    logic reset;
    pong_if bus();

    pong_engine dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Frame-level game model: signed velocities, plain integer positions.
    int m_st, m_bx, m_by, m_p1, m_p2, m_vx, m_vy, m_spd, m_hits, m_s1, m_s2, m_in_point;
    bit m_srv, m_win, m_pulse;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp;
    bit   have_last = 1'b0;
    logic ev_at_edge = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic string fmt(input logic [W-1:0] s);
        return $sformatf("bx=%0d by=%0d p1=%0d p2=%0d s1=%0d s2=%0d st=%0d w=%0d pp=%0d",
                         s[51:42], s[41:32], s[31:22], s[21:12], s[11:8], s[7:4], s[3:2], s[1], s[0]);
    endfunction

    function automatic logic [W-1:0] model_pack();
        return {10'(m_bx), 10'(m_by), 10'(m_p1), 10'(m_p2), 4'(m_s1), 4'(m_s2), 2'(m_st), m_win, m_pulse};
    endfunction

    function automatic int pad_move(input int p, input bit up, input bit dn);
        if (up) return (p - P_SPEED < BORDER) ? BORDER : p - P_SPEED;
        if (dn) return (p + P_SPEED > PY_MAX) ? PY_MAX : p + P_SPEED;
        return p;
    endfunction

    function automatic bit overlap(input int by, input int py);
        return (by + BALL_SIZE > py) && (by < py + P_HIGH);
    endfunction

    task automatic serve_pos();
        m_bx   = m_srv ? P2_FACE : P1_FACE;
        m_by   = (m_srv ? m_p2 : m_p1) + SERVE_OFS;
        m_vx   = m_srv ? -1 : 1;
        m_vy   = 1;
        m_spd  = SPEED_INIT;
        m_hits = 0;
    endtask

    task automatic model_reset();
        m_st = 0; m_srv = 0; m_p1 = PY_MID; m_p2 = PY_MID;
        m_s1 = 0; m_s2 = 0; m_win = 0; m_pulse = 0; m_in_point = 0;
        serve_pos();
    endtask

    task automatic rally_hit();
        m_hits++;
        if (m_hits == HITS_PER_STEP) begin
            m_hits = 0;
            m_spd  = (m_spd + 1 > SPEED_MAX) ? SPEED_MAX : m_spd + 1;
        end
    endtask

    task automatic model_step(input bit la, input bit u1, input bit d1, input bit u2, input bit d2);
        int n1, n2, sp, op1, op2;
        n1 = pad_move(m_p1, u1, d1);
        n2 = pad_move(m_p2, u2, d2);
        sp = m_spd; op1 = m_p1; op2 = m_p2;
        m_pulse = 0;
        case (m_st)
            0: begin
                m_p1 = n1; m_p2 = n2;
                serve_pos();
                if (la) m_st = 1;
            end
            1: begin
                m_p1 = n1; m_p2 = n2;
                if (m_vx < 0) begin
                    if (m_bx - sp <= P1_FACE && m_bx >= P1_FACE && overlap(m_by, op1)) begin
                        m_bx = P1_FACE; m_vx = 1; rally_hit();
                    end else if (m_bx - sp < BORDER) begin
                        m_s2++; m_srv = 0; m_st = 2; m_in_point = 0; m_pulse = 1;
                    end else m_bx -= sp;
                end else begin
                    if (m_bx + sp >= P2_FACE && m_bx <= P2_FACE && overlap(m_by, op2)) begin
                        m_bx = P2_FACE; m_vx = -1; rally_hit();
                    end else if (m_bx + sp > X_WALL) begin
                        m_s1++; m_srv = 1; m_st = 2; m_in_point = 0; m_pulse = 1;
                    end else m_bx += sp;
                end
                if (m_vy < 0) begin
                    if (m_by - sp < BORDER) begin m_by = BORDER; m_vy = 1; end
                    else m_by -= sp;
                end else begin
                    if (m_by + sp > Y_MAX) begin m_by = Y_MAX; m_vy = -1; end
                    else m_by += sp;
                end
            end
            2: begin
                m_in_point++;
                if (m_in_point == POINT_FRAMES) begin
                    if (m_s1 == WIN_SCORE) begin m_st = 3; m_win = 0; end
                    else if (m_s2 == WIN_SCORE) begin m_st = 3; m_win = 1; end
                    else begin m_st = 0; serve_pos(); end
                end
            end
            default: begin
                if (la) begin
                    m_s1 = 0; m_s2 = 0; m_p1 = PY_MID; m_p2 = PY_MID;
                    m_srv = !m_win; m_st = 0; serve_pos();
                end
            end
        endcase
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        logic [W-1:0] a, e;
        a = act; e = exp_v;
        if (e[3:2] != 2'd3) begin a[1] = 1'b0; e[1] = 1'b0; end
        n_checks++;
        if (a !== e) begin
            n_errors++;
            if (n_errors <= 20) $display("FAIL %s: got %s expected %s", name, fmt(a), fmt(e));
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: a frame tick or reset at an edge means the DUT presents a new frame.
    always @(posedge clk) ev_at_edge <= bus.frame_tick | reset;

    always @(negedge clk) begin
        logic [W-1:0] act, exp_v;
        act = {bus.ball_x, bus.ball_y, bus.p1_y, bus.p2_y, bus.score_p1, bus.score_p2,
               bus.state, bus.winner, bus.point_pulse};
        if (ev_at_edge) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL frame: unexpected output %s expected none", fmt(act));
            end else begin
                exp_v = exp_q.pop_front();
                check("frame", act, exp_v);
                last_exp  = exp_v;
                have_last = 1'b1;
            end
        end else if (have_last) begin
            exp_v    = last_exp;
            exp_v[0] = 1'b0;
            check("hold", act, exp_v);
        end
    end

    task automatic idle_noise();
        bus.launch  = 1'($urandom_range(0, 1));
        bus.p1_up   = 1'($urandom_range(0, 1));
        bus.p1_down = 1'($urandom_range(0, 1));
        bus.p2_up   = 1'($urandom_range(0, 1));
        bus.p2_down = 1'($urandom_range(0, 1));
    endtask

    task automatic frame(input bit la, input bit u1, input bit d1, input bit u2, input bit d2);
        bus.frame_tick = 1'b1;
        bus.launch = la; bus.p1_up = u1; bus.p1_down = d1; bus.p2_up = u2; bus.p2_down = d2;
        model_step(la, u1, d1, u2, d2);
        exp_q.push_back(model_pack());
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        idle_noise();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input bit tick);
        reset = 1'b1;
        bus.frame_tick = tick;
        idle_noise();
        model_reset();
        exp_q.push_back(model_pack());
        @(posedge clk); #1;
        reset = 1'b0;
        bus.frame_tick = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic tracked_frame(input bit la, input int jitter_pct);
        bit u1, d1, u2, d2;
        int target;
        target = m_by + BALL_SIZE / 2;
        u1 = (m_p1 + P_HIGH / 2 > target + 3); d1 = (m_p1 + P_HIGH / 2 < target - 3);
        u2 = (m_p2 + P_HIGH / 2 > target + 3); d2 = (m_p2 + P_HIGH / 2 < target - 3);
        if ($urandom_range(0, 99) < jitter_pct) begin
            u1 = 1'($urandom_range(0, 1)); d1 = 1'($urandom_range(0, 1));
            u2 = 1'($urandom_range(0, 1)); d2 = 1'($urandom_range(0, 1));
        end
        frame(la, u1, d1, u2, d2);
    endtask

    initial begin
        do_reset(1'b0);

        // Paddle clamp at the top wall with the serve ball following it.
        repeat (100) frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("p1_top", int'(bus.p1_y), BORDER);
        check_val("serve_ball_y", int'(bus.ball_y), BORDER + SERVE_OFS);
        check_val("serve_ball_x", int'(bus.ball_x), P1_FACE);

        // Straight serve with idle paddles: wall bounce, then a p2 hit or miss.
        do_reset(1'b0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (400) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Paddles chase the ball: long rallies drive the speed-up to saturation.
        do_reset(1'b0);
        repeat (2500) tracked_frame(1'($urandom_range(0, 3) == 0), 3);

        // Loose paddles: frequent misses, points, game over and restart.
        repeat (6000) tracked_frame(1'($urandom_range(0, 3) == 0), 70);

        // Reset arriving together with a frame tick in the middle of a rally.
        for (int i = 0; i < 600 && m_st != 1; i++) tracked_frame(1'b1, 0);
        repeat (5) tracked_frame(1'b0, 0);
        do_reset(1'b1);
        repeat (5) tracked_frame(1'b1, 50);

        repeat (3) @(posedge clk);
        #1;
        check_val("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
